// File: rtl/lfsr_rng_bank.sv
// lfsr_rng_bank: multi-channel Fibonacci LFSR random source.
// Each channel has its own state, its own last-loaded seed, a valid/ready
// consumer handshake, and a wrap pulse that fires when the state returns to
// that seed. Free-run mode advances every valid channel on every cycle.
// With default parameters, channel 0 reproduces the legacy 13-bit sequence.
module lfsr_rng_bank #(
    parameter int unsigned        WIDTH        = 13,
    parameter int unsigned        NUM_CH       = 4,
    parameter logic [WIDTH-1:0]   TAPS         = 13'h100D,
    parameter logic [WIDTH-1:0]   DEFAULT_SEED = 13'h0001,
    localparam int unsigned       CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    free_run,
    input  logic                    seed_load,
    input  logic [CH_W-1:0]         seed_ch,
    input  logic [WIDTH-1:0]        seed_val,
    input  logic [NUM_CH-1:0]       rnd_ready,
    output logic [NUM_CH*WIDTH-1:0] rnd,
    output logic [NUM_CH-1:0]       rnd_valid,
    output logic [NUM_CH-1:0]       wrap
);

    // A zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [WIDTH-1:0] sanitise(input logic [WIDTH-1:0] s);
        return (s == '0) ? WIDTH'(1) : s;
    endfunction

    logic [WIDTH-1:0]  state_q [NUM_CH];
    logic [WIDTH-1:0]  state_d [NUM_CH];
    logic [WIDTH-1:0]  seed_q  [NUM_CH];
    logic [WIDTH-1:0]  seed_d  [NUM_CH];
    logic [WIDTH-1:0]  step_nx [NUM_CH];
    logic [NUM_CH-1:0] valid_q, valid_d;
    logic [NUM_CH-1:0] wrap_q, wrap_d;
    logic [NUM_CH-1:0] load_hit;
    logic [NUM_CH-1:0] adv;

    // Per-channel step function, load decode, advance condition and output slice.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign step_nx[g]  = {state_q[g][WIDTH-2:0], ^(state_q[g] & TAPS)};
        assign load_hit[g] = seed_load && (32'(seed_ch) == g);
        assign adv[g]      = valid_q[g] & (free_run | rnd_ready[g]);
        assign rnd[g*WIDTH +: WIDTH] = state_q[g];
    end

    // Next state: a load beats an advance; wrap only comes from an advance.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            seed_d[i]  = seed_q[i];
            valid_d[i] = 1'b1;
            wrap_d[i]  = 1'b0;
            if (load_hit[i]) begin
                state_d[i] = sanitise(seed_val);
                seed_d[i]  = sanitise(seed_val);
                valid_d[i] = 1'b0;
            end else if (adv[i]) begin
                state_d[i] = step_nx[i];
                wrap_d[i]  = (step_nx[i] == seed_q[i]);
            end
        end
    end

    // State registers with synchronous active-low reset to per-channel seeds.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= sanitise(DEFAULT_SEED + WIDTH'(i));
                seed_q[i]  <= sanitise(DEFAULT_SEED + WIDTH'(i));
            end
            valid_q <= '0;
            wrap_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                seed_q[i]  <= seed_d[i];
            end
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign rnd_valid = valid_q;
    assign wrap      = wrap_q;

endmodule

// File: doc/lfsr_rng_bank.md
Name: lfsr_rng_bank

Overview:
- Parametrised multi-channel pseudo-random source for the PDES event engines. It generates random timestamp increments and target-LP selection.
- Each channel holds an independent WIDTH-bit maximal-length Fibonacci LFSR. Each channel has runtime seed loading, a per-channel valid/ready consumer handshake, a selectable free-running or on-demand mode, and a full-period wrap indicator.
- Replaces the fixed 13-bit single-channel LFSR; default parameters reproduce its sequence on channel 0.

Parameters:
- WIDTH, 13, LFSR state and output width per channel (>=3).
- NUM_CH, 4, number of independent channels (>=1).
- TAPS, 13'h100D, feedback tap mask, bit k = tap at stage k+1. Default is x^13+x^4+x^3+x+1, period 8191.
- DEFAULT_SEED, 13'h0001, reset seed base; channel i resets to DEFAULT_SEED+i mod 2^WIDTH.
- CH_W, max(1,$clog2(NUM_CH)), width of seed_ch (localparam-derived).

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- free_run  in  1  1 = every channel advances every cycle; 0 = channels advance only on handshake.
- seed_load  in  1  load seed_val into channel seed_ch this cycle.
- seed_ch  in  CH_W  target channel for seed_load.
- seed_val  in  WIDTH  seed value.
- rnd_ready  in  NUM_CH  per-channel consumer accept.
- rnd  out  NUM_CH*WIDTH  channel i state on bits [i*WIDTH +: WIDTH].
- rnd_valid  out  NUM_CH  per-channel output valid.
- wrap  out  NUM_CH  one-cycle pulse when a channel's state returns to its last loaded seed.

Behaviour:
- Seed sanitising: any seed equal to 0, whether from reset or load, is stored as 1. The all-zero lock-up state is never reachable.
- Reset (reset==0 at edge), per channel i:
  - state_i <= sanitised DEFAULT_SEED+i.
  - seed_reg_i <= same value.
  - rnd_valid <= 0.
  - wrap <= 0.
  - Reset overrides every other input, including mid-operation.
- Step function: fb = XOR reduction of (state & TAPS); next = {state[WIDTH-2:0], fb}.
- rnd_valid_i:
  - Rises on the first edge after reset is released.
  - Is forced to 0 for exactly one cycle after a seed load to channel i, then returns to 1.
  - Is otherwise held at 1.
- Advance condition per channel: adv_i = rnd_valid_i & (free_run | rnd_ready_i).
  - When adv_i is true, state_i <= next at the edge.
  - In on-demand mode, rnd holds stable while valid & !ready.
  - In free-run mode, rnd_ready is ignored.
- Seed load: seed_load & (seed_ch==i) sets state_i <= sanitised seed_val and seed_reg_i <= the same value.
  - Load has priority over advance in the same cycle; the handshake in that cycle does not consume a value.
  - seed_ch >= NUM_CH is ignored: no state change and no valid drop.
- wrap_i:
  - Registered; equals 1 on the cycle following an advance whose next == seed_reg_i.
  - Never asserted by a load or by reset.
  - With default TAPS, it pulses once per 8191 advances.
- Mode change: a free_run change takes effect at the next edge. State is unaffected by the mode change itself.
- Latency:
  - A seed is visible on rnd 1 cycle after load.
  - The next value is visible 1 cycle after the accepting edge.
- Channels are fully independent. Simultaneous ready on several channels advances each of them.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
- Reset defaults: hold reset low 2 cycles -> rnd ch0..3 = 0x0001, 0x0002, 0x0003, 0x0004; rnd_valid=0000; wrap=0000. First edge after release -> rnd_valid=1111, states unchanged.
- On-demand step, free_run=0:
  - Pulse rnd_ready[0] one cycle -> ch0 goes 0x0001 -> 0x0003.
  - A second pulse -> 0x0007.
  - ch1..3 unchanged.
  - rnd_ready held low for 10 cycles -> rnd constant.
- Full period, free_run=1, 8191 cycles:
  - ch0 visits 8191 distinct nonzero values and returns to 0x0001.
  - wrap[0] pulses exactly once, coincident with the return.
  - All channels wrap on the same cycle.
- Seed handling:
  - seed_load ch2 with seed_val=0 -> rnd ch2=0x0001, rnd_valid[2]=0 for one cycle.
  - seed_load ch1 with 0x1ABC together with rnd_ready[1]=1 -> rnd ch1=0x1ABC; the load wins and the ready is not consumed.
- Out-of-range channel: instance with NUM_CH=3, seed_load with seed_ch=3 -> no state or valid change on any channel.
- Reset mid-run: free_run=1, assert reset for 1 cycle after 500 steps -> next cycle states are back to reset seeds, rnd_valid=0, wrap=0, and the sequence restarts identically.
